// File: rtl/frog_controller.sv
// frog_controller: keyboard hops, pad riding, drowning, lives/score/respawn for the frog sprite
module frog_controller #(
  parameter logic [10:0] START_X = 11'd300,
  parameter logic [10:0] START_Y = 11'd440,
  parameter logic [10:0] STEP = 11'd40,
  parameter int HOP_FRAMES = 4,
  parameter logic [10:0] X_MAX = 11'd600,
  parameter logic [10:0] Y_MAX = 11'd440,
  parameter logic [10:0] GOAL_Y = 11'd0,
  parameter logic [10:0] RIVER_Y_MIN = 11'd40,
  parameter logic [10:0] RIVER_Y_MAX = 11'd200,
  parameter int DEATH_FRAMES = 30,
  parameter int LIVES = 3
) (
  input logic frame_clk,
  input logic Reset,
  input logic [7:0] keycode,
  input logic Pad_Collision,
  input logic Ride_Move,
  input logic Ride_Dir,
  input logic [10:0] Ride_Step,
  output logic [10:0] Frog_X,
  output logic [10:0] Frog_Y,
  output logic [1:0] Frog_Facing,
  output logic Frog_Hopping,
  output logic Frog_Dead,
  output logic [1:0] Lives,
  output logic [7:0] Score,
  output logic Game_Over
);
  localparam int CW = $clog2(DEATH_FRAMES > HOP_FRAMES ? DEATH_FRAMES : HOP_FRAMES) + 1;
  localparam logic [10:0] DELTA = STEP / 11'(HOP_FRAMES);
  typedef enum logic [2:0] {ALIVE, HOP, DYING, RESPAWN, OVER} state_t;
  state_t state, state_n;
  logic [7:0] prev_key;
  logic [CW-1:0] cnt, cnt_n;
  logic [10:0] x_n, y_n, hop_x, hop_y;
  logic [1:0] face_n, lives_n, key_face;
  logic [7:0] score_n;
  logic key_ev, in_bounds, river, ride_out;
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state <= ALIVE;
      Frog_X <= START_X;
      Frog_Y <= START_Y;
      Frog_Facing <= 2'd0;
      Lives <= 2'(LIVES);
      Score <= 8'd0;
      cnt <= '0;
      prev_key <= 8'd0;
    end else begin
      state <= state_n;
      Frog_X <= x_n;
      Frog_Y <= y_n;
      Frog_Facing <= face_n;
      Lives <= lives_n;
      Score <= score_n;
      cnt <= cnt_n;
      prev_key <= keycode;
    end
  end
  always_comb begin
    key_face = keycode == 8'h1A ? 2'd0 : keycode == 8'h04 ? 2'd1 : keycode == 8'h16 ? 2'd2 : 2'd3;
    key_ev = (keycode inside {8'h1A, 8'h04, 8'h16, 8'h07}) && keycode != prev_key;
    // bounds are checked on the current position so no 11-bit wrap can slip through
    in_bounds = key_face == 2'd0 ? Frog_Y >= STEP :
                key_face == 2'd1 ? Frog_X >= STEP :
                key_face == 2'd2 ? Frog_Y <= Y_MAX - STEP : Frog_X <= X_MAX - STEP;
    river = Frog_Y >= RIVER_Y_MIN && Frog_Y <= RIVER_Y_MAX;
    ride_out = Ride_Dir ? Ride_Step > X_MAX - Frog_X : Ride_Step > Frog_X;
    hop_x = Frog_Facing == 2'd1 ? Frog_X - DELTA : Frog_Facing == 2'd3 ? Frog_X + DELTA : Frog_X;
    hop_y = Frog_Facing == 2'd0 ? Frog_Y - DELTA : Frog_Facing == 2'd2 ? Frog_Y + DELTA : Frog_Y;
  end
  always_comb begin
    state_n = state;
    x_n = Frog_X;
    y_n = Frog_Y;
    face_n = Frog_Facing;
    lives_n = Lives;
    score_n = Score;
    cnt_n = cnt;
    case (state)
      ALIVE: begin
        if (key_ev) begin
          face_n = key_face;
          if (in_bounds) begin
            state_n = HOP;
            cnt_n = '0;
          end
        end else if (river && !Pad_Collision) begin
          state_n = DYING;
          cnt_n = '0;
        end else if (Pad_Collision && Ride_Move) begin
          if (ride_out) begin
            state_n = DYING;
            cnt_n = '0;
          end else x_n = Ride_Dir ? Frog_X + Ride_Step : Frog_X - Ride_Step;
        end
      end
      HOP: begin
        x_n = hop_x;
        y_n = hop_y;
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(HOP_FRAMES - 1)) begin
          state_n = hop_y == GOAL_Y ? RESPAWN : ALIVE;
          score_n = hop_y == GOAL_Y && Score != 8'hFF ? Score + 8'd1 : Score;
        end
      end
      DYING: begin
        cnt_n = cnt + CW'(1);
        if (cnt == CW'(DEATH_FRAMES - 1)) begin
          lives_n = Lives - 2'd1;
          state_n = Lives <= 2'd1 ? OVER : RESPAWN;
        end
      end
      RESPAWN: begin
        x_n = START_X;
        y_n = START_Y;
        face_n = 2'd0;
        state_n = ALIVE;
      end
      default: state_n = OVER;
    endcase
  end
  always_comb begin
    Frog_Hopping = state == HOP;
    Frog_Dead = state == DYING;
    Game_Over = state == OVER;
  end
endmodule

// File: tb/tb_frog_controller.sv
// tb_frog_controller: table vectors, directed corner sequences and a randomized run against a frame-level model
module tb_frog_controller;
  logic frame_clk, Reset, Pad_Collision, Ride_Move, Ride_Dir;
  logic [7:0] keycode;
  logic [10:0] Ride_Step, Frog_X, Frog_Y;
  logic [1:0] Frog_Facing, Lives;
  logic Frog_Hopping, Frog_Dead, Game_Over;
  logic [7:0] Score;
  int n_cmp = 0, n_bad = 0;

  frog_controller dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .Pad_Collision(Pad_Collision),
    .Ride_Move(Ride_Move), .Ride_Dir(Ride_Dir), .Ride_Step(Ride_Step), .Frog_X(Frog_X),
    .Frog_Y(Frog_Y), .Frog_Facing(Frog_Facing), .Frog_Hopping(Frog_Hopping), .Frog_Dead(Frog_Dead),
    .Lives(Lives), .Score(Score), .Game_Over(Game_Over)
  );

  initial begin
    frame_clk = 0;
    forever #5 frame_clk = ~frame_clk;
  end

  typedef struct {
    int rst, key, pad, ride, dir, step;
    int x, y, face, hop, dead;
  } vec_t;
  vec_t tv[20];

  localparam int MA = 0, MH = 1, MD = 2, MR = 3, MO = 4;
  int m_x, m_y, m_face, m_lives, m_score, m_mode, m_left, m_tx, m_ty, m_prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int k, input int pad, input int ride, input int dir, input int st, input int rst);
    keycode = 8'(k);
    Pad_Collision = pad != 0;
    Ride_Move = ride != 0;
    Ride_Dir = dir != 0;
    Ride_Step = 11'(st);
    Reset = rst != 0;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic die_wait(output int n);
    n = 0;
    for (int i = 0; i < 60 && Frog_Dead; i++) begin
      n++;
      tick(0, 1, 0, 0, 0, 0);
    end
  endtask

  task automatic hop(input int k, input int pad);
    tick(k, pad, 0, 0, 0, 0);
    repeat (4) tick(0, pad, 0, 0, 0, 0);
  endtask

  // one goal run: 11 hops up from the start row, then the respawn frame
  task automatic goal();
    for (int h = 0; h < 11; h++) hop(8'h1A, 1);
    tick(0, 1, 0, 0, 0, 0);
  endtask

  // frame-level model: hops are tracked as a destination plus frames remaining
  task automatic model_step(input int k, input int pad, input int ride, input int dir, input int st, input int rst);
    bit ev;
    int f, tx, ty, nx;
    if (rst != 0) begin
      m_x = 300; m_y = 440; m_face = 0; m_lives = 3; m_score = 0; m_mode = MA; m_left = 0; m_prev = 0;
      return;
    end
    ev = (k == 'h1A || k == 'h04 || k == 'h16 || k == 'h07) && k != m_prev;
    f = k == 'h1A ? 0 : k == 'h04 ? 1 : k == 'h16 ? 2 : 3;
    case (m_mode)
      MA: begin
        if (ev) begin
          tx = m_x + (f == 1 ? -40 : f == 3 ? 40 : 0);
          ty = m_y + (f == 0 ? -40 : f == 2 ? 40 : 0);
          m_face = f;
          if (tx >= 0 && tx <= 600 && ty >= 0 && ty <= 440) begin
            m_mode = MH; m_left = 4; m_tx = tx; m_ty = ty;
          end
        end else if (m_y >= 40 && m_y <= 200 && pad == 0) begin
          m_mode = MD; m_left = 30;
        end else if (pad != 0 && ride != 0) begin
          nx = dir != 0 ? m_x + st : m_x - st;
          if (nx < 0 || nx > 600) begin
            m_mode = MD; m_left = 30;
          end else m_x = nx;
        end
      end
      MH: begin
        m_left--;
        m_x = m_tx - m_left * (m_face == 1 ? -10 : m_face == 3 ? 10 : 0);
        m_y = m_ty - m_left * (m_face == 0 ? -10 : m_face == 2 ? 10 : 0);
        if (m_left == 0) begin
          if (m_ty == 0) begin
            m_score = m_score < 255 ? m_score + 1 : 255;
            m_mode = MR;
          end else m_mode = MA;
        end
      end
      MD: begin
        m_left--;
        if (m_left == 0) begin
          m_lives--;
          m_mode = m_lives == 0 ? MO : MR;
        end
      end
      MR: begin
        m_x = 300; m_y = 440; m_face = 0; m_mode = MA;
      end
      default: ;
    endcase
    m_prev = k;
  endtask

  function automatic logic [63:0] obs();
    return 64'({Frog_X, Frog_Y, Frog_Facing, Frog_Hopping, Frog_Dead, Lives, Score, Game_Over});
  endfunction

  function automatic logic [63:0] mdl();
    return 64'({11'(m_x), 11'(m_y), 2'(m_face), m_mode == MH, m_mode == MD, 2'(m_lives), 8'(m_score), m_mode == MO});
  endfunction

  initial begin
    int n, k, keys[6];
    keys = '{0, 'h1A, 'h04, 'h16, 'h07, 'h2C};
    tv[0] = '{1, 'h00, 1, 0, 0, 0, 300, 440, 0, 0, 0};
    tv[1] = '{0, 'h1A, 1, 1, 1, 50, 300, 440, 0, 1, 0};
    tv[2] = '{0, 'h1A, 1, 0, 0, 0, 300, 430, 0, 1, 0};
    tv[3] = '{0, 'h1A, 0, 1, 1, 50, 300, 420, 0, 1, 0};
    tv[4] = '{0, 'h1A, 1, 0, 0, 0, 300, 410, 0, 1, 0};
    tv[5] = '{0, 'h1A, 1, 0, 0, 0, 300, 400, 0, 0, 0};
    tv[6] = '{0, 'h1A, 1, 0, 0, 0, 300, 400, 0, 0, 0};
    tv[7] = '{0, 'h00, 1, 0, 0, 0, 300, 400, 0, 0, 0};
    tv[8] = '{0, 'h04, 1, 0, 0, 0, 300, 400, 1, 1, 0};
    tv[9] = '{0, 'h04, 1, 0, 0, 0, 290, 400, 1, 1, 0};
    tv[10] = '{0, 'h04, 1, 0, 0, 0, 280, 400, 1, 1, 0};
    tv[11] = '{0, 'h04, 1, 0, 0, 0, 270, 400, 1, 1, 0};
    tv[12] = '{0, 'h04, 1, 0, 0, 0, 260, 400, 1, 0, 0};
    tv[13] = '{0, 'h07, 1, 0, 0, 0, 260, 400, 3, 1, 0};
    tv[14] = '{0, 'h07, 1, 0, 0, 0, 270, 400, 3, 1, 0};
    tv[15] = '{0, 'h07, 1, 0, 0, 0, 280, 400, 3, 1, 0};
    tv[16] = '{0, 'h07, 1, 0, 0, 0, 290, 400, 3, 1, 0};
    tv[17] = '{0, 'h07, 1, 0, 0, 0, 300, 400, 3, 0, 0};
    tv[18] = '{0, 'h00, 1, 1, 1, 50, 350, 400, 3, 0, 0};
    tv[19] = '{0, 'h00, 1, 1, 0, 60, 290, 400, 3, 0, 0};
    for (int i = 0; i < 20; i++) begin
      tick(tv[i].key, tv[i].pad, tv[i].ride, tv[i].dir, tv[i].step, tv[i].rst);
      chk($sformatf("vec%0d", i), 64'({Frog_X, Frog_Y, Frog_Facing, Frog_Hopping, Frog_Dead, Lives, Score}),
          64'({11'(tv[i].x), 11'(tv[i].y), 2'(tv[i].face), tv[i].hop != 0, tv[i].dead != 0, 2'd3, 8'd0}));
    end

    // left edge reached by riding, blocked hop, then ride off the edge
    tick(0, 1, 0, 0, 0, 1);
    for (int h = 0; h < 7; h++) hop('h04, 1);
    chk("x_before_ride", 64'(Frog_X), 64'd20);
    tick(0, 1, 1, 0, 20, 0);
    chk("ride_to_zero", 64'({Frog_X, Frog_Dead}), 64'({11'd0, 1'b0}));
    tick('h04, 1, 0, 0, 0, 0);
    chk("blocked_left", 64'({Frog_Facing, Frog_Hopping, Frog_X}), 64'({2'd1, 1'b0, 11'd0}));
    tick(0, 1, 1, 0, 20, 0);
    chk("ride_off_left", 64'({Frog_Dead, Frog_X}), 64'({1'b1, 11'd0}));
    die_wait(n);
    chk("ride_death_len", 64'(n), 64'd30);

    // drown after hopping onto open water
    tick(0, 1, 0, 0, 0, 1);
    for (int h = 0; h < 6; h++) hop('h1A, 0);
    chk("land_y200", 64'({Frog_Y, Frog_Dead}), 64'({11'd200, 1'b0}));
    tick(0, 0, 0, 0, 0, 0);
    chk("drown_start", 64'(Frog_Dead), 64'd1);
    die_wait(n);
    chk("drown_len", 64'(n), 64'd30);
    chk("drown_lives", 64'({Lives, Game_Over}), 64'({2'd2, 1'b0}));
    tick(0, 1, 0, 0, 0, 0);
    chk("drown_respawn", 64'({Frog_X, Frog_Y, Frog_Facing}), 64'({11'd300, 11'd440, 2'd0}));

    // goal scoring and saturation
    tick(0, 1, 0, 0, 0, 1);
    for (int h = 0; h < 11; h++) hop('h1A, 1);
    chk("goal_first", 64'({Frog_Y, Score}), 64'({11'd0, 8'd1}));
    tick(0, 1, 0, 0, 0, 0);
    chk("goal_respawn", 64'({Frog_X, Frog_Y, Frog_Hopping}), 64'({11'd300, 11'd440, 1'b0}));
    for (int g = 0; g < 254; g++) goal();
    chk("score_255", 64'(Score), 64'd255);
    goal();
    chk("score_sat", 64'(Score), 64'd255);

    // three deaths end the game; reset mid-dying and mid-hop
    tick(0, 1, 0, 0, 0, 1);
    for (int d = 0; d < 3; d++) begin
      tick(0, 1, 1, 1, 400, 0);
      die_wait(n);
      tick(0, 1, 0, 0, 0, 0);
    end
    chk("game_over", 64'({Game_Over, Lives}), 64'({1'b1, 2'd0}));
    tick('h1A, 1, 0, 0, 0, 0);
    chk("over_frozen", 64'({Frog_Hopping, Frog_Y, Game_Over}), 64'({1'b0, 11'd440, 1'b1}));
    tick(0, 1, 0, 0, 0, 1);
    tick(0, 1, 1, 1, 400, 0);
    repeat (10) tick(0, 1, 0, 0, 0, 0);
    chk("mid_dying", 64'(Frog_Dead), 64'd1);
    tick(0, 1, 0, 0, 0, 1);
    chk("reset_dying", obs(), 64'({11'd300, 11'd440, 2'd0, 1'b0, 1'b0, 2'd3, 8'd0, 1'b0}));
    tick('h16, 1, 0, 0, 0, 0);
    tick('h04, 1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 1);
    chk("reset_hop", obs(), 64'({11'd300, 11'd440, 2'd0, 1'b0, 1'b0, 2'd3, 8'd0, 1'b0}));

    // randomized run against the model
    k = 0;
    for (int i = 0; i < 4000; i++) begin
      int pad, ride, dir, st, rst;
      if ($urandom_range(0, 2) == 0) k = keys[$urandom_range(0, 5)];
      pad = $urandom_range(0, 3) != 0;
      ride = $urandom_range(0, 2) == 0;
      dir = $urandom_range(0, 1);
      st = $urandom_range(0, 7) == 0 ? $urandom_range(0, 700) : $urandom_range(0, 80);
      rst = i % 400 == 0;
      model_step(k, pad, ride, dir, st, rst);
      tick(k, pad, ride, dir, st, rst);
      chk($sformatf("rand%0d", i), obs(), mdl());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
